// File: rtl/fetch_pc_unit.sv
// IF-stage PC sequencer: issues one instruction-memory fetch at a time, buffers one
// instruction toward decode, and discards responses that became stale because of a redirect.
module fetch_pc_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            io_pcsrc,
   input  logic [XLEN-1:0] io_branch_target,
   output logic            io_imem_req_valid,
   input  logic            io_imem_req_ready,
   output logic [XLEN-1:0] io_imem_req_addr,
   input  logic            io_imem_resp_valid,
   input  logic [XLEN-1:0] io_imem_resp_data,
   output logic            io_if_valid,
   output logic [XLEN-1:0] io_if_pc,
   output logic [XLEN-1:0] io_if_instr,
   input  logic            io_if_ready
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pending_pc_q, pending_pc_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [XLEN-1:0] if_instr_q, if_instr_d;

   logic            consume_s;
   logic            space_s;
   logic            req_valid_s;
   logic            req_fire_s;
   logic            redirect_s;
   logic [XLEN-1:0] target_s;

   assign consume_s   = if_valid_q & io_if_ready;
   assign space_s     = ~if_valid_q | consume_s;
   // Issue only when the buffer can absorb the response, so a returning word is never lost.
   assign req_valid_s = (state_q == ST_REQ) & space_s & ~io_pcsrc;
   assign req_fire_s  = req_valid_s & io_imem_req_ready;
   assign redirect_s  = io_pcsrc & (state_q != ST_BOOT);
   assign target_s    = io_branch_target & ~{{(XLEN-2){1'b0}}, 2'b11};

   assign io_imem_req_valid = req_valid_s;
   assign io_imem_req_addr  = pc_q;
   assign io_if_valid       = if_valid_q;
   assign io_if_pc          = if_pc_q;
   assign io_if_instr       = if_instr_q;

   // Next-state for sequencer, PC and decode buffer; redirect overrides everything else.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pending_pc_d = pending_pc_q;
      if_valid_d   = if_valid_q;
      if_pc_d      = if_pc_q;
      if_instr_d   = if_instr_q;

      if (consume_s) begin
         if_valid_d = 1'b0;
      end else begin
         if_valid_d = if_valid_q;
      end

      case (state_q)
         ST_BOOT: state_d = ST_REQ;
         ST_REQ: begin
            if (req_fire_s) begin
               pending_pc_d = pc_q;
               pc_d         = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
               state_d      = ST_WAIT;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (io_imem_resp_valid) begin
               state_d = ST_REQ;
               if (!io_pcsrc) begin
                  if_valid_d = 1'b1;
                  if_pc_d    = pending_pc_q;
                  if_instr_d = io_imem_resp_data;
               end else begin
                  if_instr_d = if_instr_q;
               end
            end else if (io_pcsrc) begin
               state_d = ST_DROP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DROP: begin
            if (io_imem_resp_valid) begin
               state_d = ST_REQ;
            end else begin
               state_d = ST_DROP;
            end
         end
         default: state_d = ST_BOOT;
      endcase

      if (redirect_s) begin
         pc_d       = target_s;
         if_valid_d = 1'b0;
      end else begin
         pending_pc_d = pending_pc_d;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_PC;
         pending_pc_q <= {XLEN{1'b0}};
         if_valid_q   <= 1'b0;
         if_pc_q      <= {XLEN{1'b0}};
         if_instr_q   <= {XLEN{1'b0}};
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pending_pc_q <= pending_pc_d;
         if_valid_q   <= if_valid_d;
         if_pc_q      <= if_pc_d;
         if_instr_q   <= if_instr_d;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed cycle-by-cycle vectors for fetch_pc_unit plus a hand-written reset sequence.
module tb_fetch_pc_unit;

   logic        clock;
   logic        reset;
   logic        io_pcsrc;
   logic [31:0] io_branch_target;
   logic        io_imem_req_valid;
   logic        io_imem_req_ready;
   logic [31:0] io_imem_req_addr;
   logic        io_imem_resp_valid;
   logic [31:0] io_imem_resp_data;
   logic        io_if_valid;
   logic [31:0] io_if_pc;
   logic [31:0] io_if_instr;
   logic        io_if_ready;

   int total;
   int bad;

   fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clock              (clock),
      .reset              (reset),
      .io_pcsrc           (io_pcsrc),
      .io_branch_target   (io_branch_target),
      .io_imem_req_valid  (io_imem_req_valid),
      .io_imem_req_ready  (io_imem_req_ready),
      .io_imem_req_addr   (io_imem_req_addr),
      .io_imem_resp_valid (io_imem_resp_valid),
      .io_imem_resp_data  (io_imem_resp_data),
      .io_if_valid        (io_if_valid),
      .io_if_pc           (io_if_pc),
      .io_if_instr        (io_if_instr),
      .io_if_ready        (io_if_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        pcsrc;
      logic [31:0] tgt;
      logic        rdy;
      logic        rv;
      logic [31:0] rdata;
      logic        ifr;
      logic        e_rv;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_ipc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic pcsrc, input logic [31:0] tgt, input logic rdy,
                      input logic rv, input logic [31:0] rdata, input logic ifr,
                      input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                      input logic [31:0] e_ipc, input logic [31:0] e_instr);
      vec_t v;
      v.pcsrc = pcsrc; v.tgt = tgt; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.ifr = ifr;
      v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_instr = e_instr;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_rv, input logic [31:0] e_addr,
                          input logic e_iv, input logic [31:0] e_ipc, input logic [31:0] e_instr);
      chk({tag, ".req_valid"}, {31'd0, io_imem_req_valid}, {31'd0, e_rv});
      chk({tag, ".req_addr"},  io_imem_req_addr, e_addr);
      chk({tag, ".if_valid"},  {31'd0, io_if_valid}, {31'd0, e_iv});
      chk({tag, ".if_pc"},     io_if_pc, e_ipc);
      chk({tag, ".if_instr"},  io_if_instr, e_instr);
   endtask

   task automatic drive(input logic pcsrc, input logic [31:0] tgt, input logic rdy,
                        input logic rv, input logic [31:0] rdata, input logic ifr);
      io_pcsrc           = pcsrc;
      io_branch_target   = tgt;
      io_imem_req_ready  = rdy;
      io_imem_resp_valid = rv;
      io_imem_resp_data  = rdata;
      io_if_ready        = ifr;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);

      // pcsrc tgt rdy rv rdata ifr | req_valid addr if_valid if_pc if_instr
      // sequential fetch 0,4,8 (1 instr per 2 cycles)
      add(0, 32'h0, 1, 0, 32'h0,         1,  0, 32'h0,        0, 32'h0,        32'h0);
      add(0, 32'h0, 1, 0, 32'h0,         1,  1, 32'h0,        0, 32'h0,        32'h0);
      add(0, 32'h0, 1, 1, 32'h1111_0000, 1,  0, 32'h4,        0, 32'h0,        32'h0);
      add(0, 32'h0, 1, 0, 32'h0,         1,  1, 32'h4,        1, 32'h0,        32'h1111_0000);
      add(0, 32'h0, 1, 1, 32'h1111_0004, 1,  0, 32'h8,        0, 32'h0,        32'h1111_0000);
      add(0, 32'h0, 1, 0, 32'h0,         1,  1, 32'h8,        1, 32'h4,        32'h1111_0004);
      add(0, 32'h0, 1, 1, 32'h1111_0008, 1,  0, 32'hC,        0, 32'h4,        32'h1111_0004);
      // decode stall with full buffer
      add(0, 32'h0, 1, 0, 32'h0,         0,  0, 32'hC,        1, 32'h8,        32'h1111_0008);
      add(0, 32'h0, 1, 0, 32'h0,         0,  0, 32'hC,        1, 32'h8,        32'h1111_0008);
      add(0, 32'h0, 1, 0, 32'h0,         1,  1, 32'hC,        1, 32'h8,        32'h1111_0008);
      add(0, 32'h0, 1, 1, 32'h1111_000C, 1,  0, 32'h10,       0, 32'h8,        32'h1111_0008);
      add(0, 32'h0, 1, 0, 32'h0,         0,  0, 32'h10,       1, 32'hC,        32'h1111_000C);
      add(0, 32'h0, 1, 0, 32'h0,         1,  1, 32'h10,       1, 32'hC,        32'h1111_000C);
      // redirect in WAIT, stale response two cycles later
      add(1, 32'h100, 1, 0, 32'h0,       1,  0, 32'h14,       0, 32'hC,        32'h1111_000C);
      add(0, 32'h0, 1, 0, 32'h0,         1,  0, 32'h100,      0, 32'hC,        32'h1111_000C);
      add(0, 32'h0, 1, 1, 32'hDEAD_BEEF, 1,  0, 32'h100,      0, 32'hC,        32'h1111_000C);
      add(0, 32'h0, 1, 0, 32'h0,         1,  1, 32'h100,      0, 32'hC,        32'h1111_000C);
      // redirect coincident with response, unaligned target
      add(1, 32'h103, 1, 1, 32'h0BAD_0BAD, 1, 0, 32'h104,     0, 32'hC,        32'h1111_000C);
      add(0, 32'h0, 0, 0, 32'h0,         1,  1, 32'h100,      0, 32'hC,        32'h1111_000C);
      add(0, 32'h0, 1, 0, 32'h0,         1,  1, 32'h100,      0, 32'hC,        32'h1111_000C);
      add(0, 32'h0, 1, 1, 32'h2222_0100, 1,  0, 32'h104,      0, 32'hC,        32'h1111_000C);
      // redirect in REQ to top of address space, then wrap
      add(1, 32'hFFFF_FFFE, 1, 0, 32'h0, 1,  0, 32'h104,      1, 32'h100,      32'h2222_0100);
      add(0, 32'h0, 1, 0, 32'h0,         1,  1, 32'hFFFF_FFFC, 0, 32'h100,     32'h2222_0100);
      add(0, 32'h0, 1, 1, 32'h3333_FFFC, 1,  0, 32'h0,        0, 32'h100,      32'h2222_0100);
      add(0, 32'h0, 1, 0, 32'h0,         1,  1, 32'h0,        1, 32'hFFFF_FFFC, 32'h3333_FFFC);
      add(0, 32'h0, 1, 0, 32'h0,         1,  0, 32'h4,        0, 32'hFFFF_FFFC, 32'h3333_FFFC);

      repeat (2) @(negedge clock);
      #1;
      chk_all("in_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].pcsrc, vq[i].tgt, vq[i].rdy, vq[i].rv, vq[i].rdata, vq[i].ifr);
         #1;
         chk_all($sformatf("vec%0d", i), vq[i].e_rv, vq[i].e_addr, vq[i].e_iv,
                 vq[i].e_ipc, vq[i].e_instr);
         @(negedge clock);
      end

      // Asynchronous reset while in WAIT, then BOOT ignores a redirect.
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk_all("rst_async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
      chk_all("rst_hold", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      drive(1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 1'b1);
      #1;
      chk_all("boot", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      #1;
      chk_all("first_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
